periph_arb: RTL

PERIPH_ARB -- requirements
Module: periph_arb

---
 rtl/periph_arb_pkg.sv | 46 ++++
 rtl/periph_arb_if.sv | 28 ++
 rtl/spi_shifter.sv | 119 +++++++++++
 rtl/periph_arb.sv | 89 ++++++++
 4 files changed

// File: rtl/periph_arb_pkg.sv
// Shared types and constants for the DAC / digital-pot serial arbiter.
// Optional build macro: PERIPH_ARB_FIXED_PRIO_EN (fixed DAC priority, no round-robin pointer).
package periph_arb_pkg;

    localparam int unsigned DAC_BITS   = 16;
    localparam int unsigned DPOT_BITS  = 10;
    localparam int unsigned DPOT_CH_W  = 2;
    localparam int unsigned DPOT_VAL_W = 8;
    localparam int unsigned FRAME_W    = DAC_BITS;
    localparam int unsigned BITCNT_W   = 4;
    localparam int unsigned DIV_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_DAC  = 1'b0,
        REQ_DPOT = 1'b1
    } req_id_e;

    // Frame handed to the shifter: MSB-aligned payload plus index of the final bit
    typedef struct packed {
        logic [FRAME_W-1:0]  data;
        logic [BITCNT_W-1:0] last_bit;
    } frame_t;

    function automatic frame_t dac_frame(input logic [DAC_BITS-1:0] d);
        frame_t f;
        f.data     = d;
        f.last_bit = BITCNT_W'(DAC_BITS - 1);
        return f;
    endfunction

    function automatic frame_t dpot_frame(input logic [DPOT_CH_W-1:0]  ch,
                                          input logic [DPOT_VAL_W-1:0] val);
        frame_t f;
        f.data     = {ch, val, {(FRAME_W - DPOT_BITS){1'b0}}};
        f.last_bit = BITCNT_W'(DPOT_BITS - 1);
        return f;
    endfunction

endpackage

// File: rtl/periph_arb_if.sv
// Request/ack and shared serial-bus signals between the arbiter and its environment.
interface periph_arb_if;
    import periph_arb_pkg::*;

    logic                  dac_req;
    logic [DAC_BITS-1:0]   dac_data;
    logic                  dac_ack;
    logic                  dpot_req;
    logic [DPOT_CH_W-1:0]  dpot_ch;
    logic [DPOT_VAL_W-1:0] dpot_data;
    logic                  dpot_ack;
    logic                  sclk;
    logic                  sdo;
    logic                  dac_cs_n;
    logic                  dpot_cs_n;
    logic                  busy;
    logic                  done;

    modport slave (
        input  dac_req, dac_data, dpot_req, dpot_ch, dpot_data,
        output dac_ack, dpot_ack, sclk, sdo, dac_cs_n, dpot_cs_n, busy, done
    );

    modport master (
        output dac_req, dac_data, dpot_req, dpot_ch, dpot_data,
        input  dac_ack, dpot_ack, sclk, sdo, dac_cs_n, dpot_cs_n, busy, done
    );
endinterface

// File: rtl/spi_shifter.sv
// Frame sequencer: IDLE/SHIFT/HOLD/GAP, sclk divider, MSB-first sdo, busy and done strobe.
module spi_shifter
    import periph_arb_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_start,
    input  frame_t i_frame,
    output logic   o_idle_c,
    output logic   o_cs_low_nxt_c,
    output logic   o_sclk,
    output logic   o_sdo,
    output logic   o_busy,
    output logic   o_done
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    arb_state_e          r_state, w_state_nxt;
    logic [DIV_W-1:0]    r_div, w_div_nxt;
    logic [BITCNT_W-1:0] r_bit, w_bit_nxt;
    logic [FRAME_W-1:0]  r_shreg, w_shreg_nxt;
    logic                r_sclk, w_sclk_nxt;
    logic                r_sdo, w_sdo_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                w_div_end;

    assign w_div_end      = (r_div == DIV_LAST);
    assign o_idle_c       = (r_state == ST_IDLE);
    assign o_cs_low_nxt_c = (w_state_nxt == ST_SHIFT) || (w_state_nxt == ST_HOLD);
    assign o_sclk         = r_sclk;
    assign o_sdo          = r_sdo;
    assign o_busy         = r_busy;
    assign o_done         = r_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
            r_sclk  <= 1'b0;
            r_sdo   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_shreg <= w_shreg_nxt;
            r_sclk  <= w_sclk_nxt;
            r_sdo   <= w_sdo_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Each phase runs for CLK_DIV cycles; a bit is one low phase followed by one high phase
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_bit_nxt   = r_bit;
        w_shreg_nxt = r_shreg;
        w_sclk_nxt  = r_sclk;
        w_sdo_nxt   = r_sdo;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_SHIFT;
                    w_div_nxt   = '0;
                    w_bit_nxt   = i_frame.last_bit;
                    w_sdo_nxt   = i_frame.data[FRAME_W-1];
                    w_shreg_nxt = i_frame.data << 1;
                    w_sclk_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_SHIFT: begin
                w_div_nxt = w_div_end ? '0 : r_div + DIV_W'(1);
                if (w_div_end) begin
                    if (!r_sclk) begin
                        w_sclk_nxt = 1'b1;
                    end else begin
                        w_sclk_nxt = 1'b0;
                        if (r_bit == '0) begin
                            w_state_nxt = ST_HOLD;
                        end else begin
                            w_bit_nxt   = r_bit - BITCNT_W'(1);
                            w_sdo_nxt   = r_shreg[FRAME_W-1];
                            w_shreg_nxt = r_shreg << 1;
                        end
                    end
                end
            end
            ST_HOLD: begin
                w_div_nxt = w_div_end ? '0 : r_div + DIV_W'(1);
                if (w_div_end) begin
                    w_state_nxt = ST_GAP;
                    w_done_nxt  = 1'b1;
                end
            end
            ST_GAP: begin
                w_div_nxt = w_div_end ? '0 : r_div + DIV_W'(1);
                if (w_div_end) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/periph_arb.sv
// Arbitrates DAC and digital-pot write requests onto one shared serial bus.
// Build macro PERIPH_ARB_FIXED_PRIO_EN: DAC always wins ties; otherwise round-robin.
module periph_arb
    import periph_arb_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    periph_arb_if.slave bus
);

    logic    w_idle_c;
    logic    w_cs_low_nxt_c;
    logic    w_grant_dac;
    logic    w_grant_dpot;
    logic    w_start;
    req_id_e r_sel, w_sel_nxt;
    frame_t  w_frame;
    logic    r_dac_cs_n;
    logic    r_dpot_cs_n;
`ifndef PERIPH_ARB_FIXED_PRIO_EN
    req_id_e r_last;
`endif

    // Grants only in IDLE and never while reset is being applied
    always_comb begin
        w_grant_dac  = 1'b0;
        w_grant_dpot = 1'b0;
        if (w_idle_c && rst_n) begin
`ifdef PERIPH_ARB_FIXED_PRIO_EN
            w_grant_dac  = bus.dac_req;
            w_grant_dpot = bus.dpot_req && !bus.dac_req;
`else
            w_grant_dac  = bus.dac_req  && (!bus.dpot_req || (r_last == REQ_DPOT));
            w_grant_dpot = bus.dpot_req && (!bus.dac_req  || (r_last == REQ_DAC));
`endif
        end
    end

    assign w_start   = w_grant_dac || w_grant_dpot;
    assign w_sel_nxt = w_grant_dpot ? REQ_DPOT : (w_grant_dac ? REQ_DAC : r_sel);
    assign w_frame   = w_grant_dpot ? dpot_frame(bus.dpot_ch, bus.dpot_data)
                                    : dac_frame(bus.dac_data);

    assign bus.dac_ack   = w_grant_dac;
    assign bus.dpot_ack  = w_grant_dpot;
    assign bus.dac_cs_n  = r_dac_cs_n;
    assign bus.dpot_cs_n = r_dpot_cs_n;

    // Chip selects follow the shifter's next state so they switch on the same edge as sclk/done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel       <= REQ_DAC;
            r_dac_cs_n  <= 1'b1;
            r_dpot_cs_n <= 1'b1;
        end else begin
            r_sel       <= w_sel_nxt;
            r_dac_cs_n  <= !(w_cs_low_nxt_c && (w_sel_nxt == REQ_DAC));
            r_dpot_cs_n <= !(w_cs_low_nxt_c && (w_sel_nxt == REQ_DPOT));
        end
    end

`ifndef PERIPH_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= REQ_DPOT;
        end else if (w_start) begin
            r_last <= w_sel_nxt;
        end
    end
`endif

    spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (w_start),
        .i_frame        (w_frame),
        .o_idle_c       (w_idle_c),
        .o_cs_low_nxt_c (w_cs_low_nxt_c),
        .o_sclk         (bus.sclk),
        .o_sdo          (bus.sdo),
        .o_busy         (bus.busy),
        .o_done         (bus.done)
    );

endmodule
